// File: rtl/instr_encoder_loader.sv
// Program loader: encodes symbolic RV32I instructions into 32-bit words and
// writes them into instruction memory at consecutive word addresses.
module instr_encoder_loader #(
    parameter int unsigned IMEM_AW = 6
) (
    input  logic               i_Clk,
    input  logic               i_Reset_n,
    input  logic               i_Start,
    input  logic               i_Valid,
    output logic               o_Ready,
    input  logic [2:0]         i_Class,
    input  logic [4:0]         i_Rd,
    input  logic [4:0]         i_Rs1,
    input  logic [4:0]         i_Rs2,
    input  logic [2:0]         i_Funct3,
    input  logic               i_Funct7b5,
    input  logic [31:0]        i_Imm,
    output logic               o_MemWE,
    output logic [IMEM_AW-1:0] o_MemAddr,
    output logic [31:0]        o_MemWData,
    output logic [IMEM_AW:0]   o_Count,
    output logic               o_Full,
    output logic               o_Error,
    output logic [1:0]         o_ErrCode
);

    typedef enum logic [1:0] {StIdle, StAccept, StWrite, StFull} state_t;

    localparam logic [1:0] ErrNone  = 2'b00;
    localparam logic [1:0] ErrClass = 2'b01;
    localparam logic [1:0] ErrRange = 2'b10;
    localparam logic [1:0] ErrAlign = 2'b11;

    // Count value seen in the WRITE cycle that fills the memory.
    localparam logic [IMEM_AW:0] LastCount = (IMEM_AW + 1)'((1 << IMEM_AW) - 1);

    state_t               state_q;
    logic                 ready_q;
    logic [IMEM_AW-1:0]   ptr_q;
    logic [IMEM_AW:0]     count_q;
    logic                 full_q;
    logic                 error_q;
    logic [1:0]           err_code_q;
    logic [31:0]          word_q;

    logic [31:0]          enc_word;
    logic [1:0]           enc_err;
    logic signed [31:0]   imm_s;
    logic                 in_i_range;
    logic                 in_b_range;
    logic                 in_j_range;

    assign imm_s      = signed'(i_Imm);
    assign in_i_range = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
    assign in_b_range = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4095);
    assign in_j_range = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048575);

    // Encode the current beat and classify it as legal or as the first-failing error.
    always_comb begin
        enc_word = 32'h0;
        enc_err  = ErrNone;
        unique case (i_Class)
            3'd0: begin
                enc_word = {i_Imm[11:0], i_Rs1, 3'b010, i_Rd, 7'b0000011};
                if (!in_i_range) enc_err = ErrRange;
            end
            3'd1: begin
                enc_word = {i_Imm[11:5], i_Rs2, i_Rs1, 3'b010, i_Imm[4:0], 7'b0100011};
                if (!in_i_range) enc_err = ErrRange;
            end
            3'd2: begin
                enc_word = {1'b0, i_Funct7b5, 5'b0, i_Rs2, i_Rs1, i_Funct3, i_Rd, 7'b0110011};
            end
            3'd3: begin
                enc_word = {i_Imm[12], i_Imm[10:5], i_Rs2, i_Rs1, 3'b000, i_Imm[4:1],
                            i_Imm[11], 7'b1100011};
                if (!in_b_range)   enc_err = ErrRange;
                else if (i_Imm[0]) enc_err = ErrAlign;
            end
            3'd4: begin
                enc_word = {i_Imm[11:0], i_Rs1, i_Funct3, i_Rd, 7'b0010011};
                if (!in_i_range) enc_err = ErrRange;
            end
            3'd5: begin
                enc_word = {i_Imm[20], i_Imm[10:1], i_Imm[11], i_Imm[19:12], i_Rd, 7'b1101111};
                if (!in_j_range)   enc_err = ErrRange;
                else if (i_Imm[0]) enc_err = ErrAlign;
            end
            default: begin
                enc_err = ErrClass;
            end
        endcase
    end

    // Session FSM with registered status outputs; i_Start overrides every state.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q    <= StIdle;
            ready_q    <= 1'b0;
            ptr_q      <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 2'b00;
            word_q     <= 32'h0;
        end else if (i_Start) begin
            // Any same-cycle handshake or pending write is dropped.
            state_q    <= StAccept;
            ready_q    <= 1'b1;
            ptr_q      <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    ready_q <= 1'b0;
                end
                StAccept: begin
                    if (i_Valid && ready_q) begin
                        if (enc_err == ErrNone) begin
                            word_q  <= enc_word;
                            state_q <= StWrite;
                            ready_q <= 1'b0;
                        end else begin
                            error_q    <= 1'b1;
                            err_code_q <= enc_err;
                        end
                    end
                end
                StWrite: begin
                    // The pointer wraps to 0 exactly when the last slot is written.
                    ptr_q   <= ptr_q + 1'b1;
                    count_q <= count_q + 1'b1;
                    if (count_q == LastCount) begin
                        state_q <= StFull;
                        full_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end else begin
                        state_q <= StAccept;
                        ready_q <= 1'b1;
                    end
                end
                StFull: begin
                    ready_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // i_Start during WRITE suppresses the strobe in that same cycle.
    assign o_MemWE    = (state_q == StWrite) && !i_Start;
    assign o_Ready    = ready_q;
    assign o_MemAddr  = ptr_q;
    assign o_MemWData = word_q;
    assign o_Count    = count_q;
    assign o_Full     = full_q;
    assign o_Error    = error_q;
    assign o_ErrCode  = err_code_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: a driver pushes expected IMEM writes,
// a negedge monitor pops and compares every strobe the DUT produces.
module tb_instr_encoder_loader;

    localparam int unsigned AW  = 2;
    localparam int unsigned CAP = 1 << AW;

    logic          i_Clk = 1'b0;
    logic          i_Reset_n;
    logic          i_Start;
    logic          i_Valid;
    logic          o_Ready;
    logic [2:0]    i_Class;
    logic [4:0]    i_Rd;
    logic [4:0]    i_Rs1;
    logic [4:0]    i_Rs2;
    logic [2:0]    i_Funct3;
    logic          i_Funct7b5;
    logic [31:0]   i_Imm;
    logic          o_MemWE;
    logic [AW-1:0] o_MemAddr;
    logic [31:0]   o_MemWData;
    logic [AW:0]   o_Count;
    logic          o_Full;
    logic          o_Error;
    logic [1:0]    o_ErrCode;

    instr_encoder_loader #(.IMEM_AW(AW)) dut (
        .i_Clk      (i_Clk),
        .i_Reset_n  (i_Reset_n),
        .i_Start    (i_Start),
        .i_Valid    (i_Valid),
        .o_Ready    (o_Ready),
        .i_Class    (i_Class),
        .i_Rd       (i_Rd),
        .i_Rs1      (i_Rs1),
        .i_Rs2      (i_Rs2),
        .i_Funct3   (i_Funct3),
        .i_Funct7b5 (i_Funct7b5),
        .i_Imm      (i_Imm),
        .o_MemWE    (o_MemWE),
        .o_MemAddr  (o_MemAddr),
        .o_MemWData (o_MemWData),
        .o_Count    (o_Count),
        .o_Full     (o_Full),
        .o_Error    (o_Error),
        .o_ErrCode  (o_ErrCode)
    );

    always #5 i_Clk = ~i_Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected writes: {address, word}.
    logic [AW+31:0] exp_q[$];

    // Reference session state.
    int          m_ptr;
    int          m_count;
    bit          m_full;
    bit          m_err;
    logic [1:0]  m_code;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Rejection code from the validation rules, in priority order.
    function automatic logic [1:0] model_err(input int cls, input int imm);
        bit odd = (imm % 2) != 0;
        case (cls)
            0, 1, 4: return (imm < -2048 || imm > 2047) ? 2'b10 : 2'b00;
            2:       return 2'b00;
            3:       return (imm < -4096 || imm > 4095) ? 2'b10 : (odd ? 2'b11 : 2'b00);
            5:       return (imm < -1048576 || imm > 1048575) ? 2'b10 : (odd ? 2'b11 : 2'b00);
            default: return 2'b01;
        endcase
    endfunction

    // Instruction word built field by field with shifts and masks.
    function automatic logic [31:0] model_word(input int cls, input int rd, input int rs1,
                                               input int rs2, input int f3, input int f7,
                                               input int imm);
        logic [31:0] u = imm;
        logic [31:0] w = 0;
        case (cls)
            0: w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 32'h03;
            1: w = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                   | ((u & 32'h1F) << 7) | 32'h23;
            2: w = (f7 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
            3: w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20)
                   | (rs1 << 15) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
            4: w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
            5: w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                   | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
            default: w = 0;
        endcase
        return w;
    endfunction

    task automatic model_clear();
        m_ptr = 0; m_count = 0; m_full = 0; m_err = 0; m_code = 2'b00;
    endtask

    task automatic set_fields(input int cls, input int rd, input int rs1, input int rs2,
                              input int f3, input int f7, input int imm);
        i_Class = 3'(cls); i_Rd = 5'(rd); i_Rs1 = 5'(rs1); i_Rs2 = 5'(rs2);
        i_Funct3 = 3'(f3); i_Funct7b5 = 1'(f7); i_Imm = imm;
    endtask

    task automatic start_session();
        i_Start = 1'b1;
        @(posedge i_Clk); #1;
        i_Start = 1'b0;
        model_clear();
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!o_Ready && n < 50) begin
            @(posedge i_Clk); #1;
            n++;
        end
        ok = o_Ready;
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL ready_timeout: got o_Ready=0 expected 1 at %0t", $time);
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_count"}, 32'(o_Count), 32'(m_count));
        chk({tag, "_addr"}, 32'(o_MemAddr), 32'(m_ptr));
        chk({tag, "_full"}, 32'(o_Full), 32'(m_full));
        chk({tag, "_error"}, 32'(o_Error), 32'(m_err));
        chk({tag, "_errcode"}, 32'(o_ErrCode), 32'(m_code));
    endtask

    // One beat; use_const substitutes a hand-computed expected word.
    task automatic beat(input int cls, input int rd, input int rs1, input int rs2,
                        input int f3, input int f7, input int imm,
                        input bit use_const, input logic [31:0] cword);
        bit ok;
        logic [1:0]  e;
        logic [31:0] w;
        set_fields(cls, rd, rs1, rs2, f3, f7, imm);
        i_Valid = 1'b1;
        wait_ready(ok);
        if (!ok) begin
            i_Valid = 1'b0;
            return;
        end
        e = model_err(cls, imm);
        if (e == 2'b00) begin
            w = use_const ? cword : model_word(cls, rd, rs1, rs2, f3, f7, imm);
            exp_q.push_back({AW'(m_ptr), w});
            m_count++;
            m_ptr = (m_ptr + 1) % CAP;
            if (m_count == CAP) m_full = 1;
        end else begin
            m_err  = 1;
            m_code = e;
        end
        @(posedge i_Clk); #1;
        i_Valid = 1'b0;
        @(posedge i_Clk); #1;
        check_status("beat");
    endtask

    // Monitor: every strobe must match the oldest expected write.
    always @(negedge i_Clk) begin
        if (o_MemWE) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %h expected no write at %0t",
                         o_MemAddr, o_MemWData, $time);
            end else begin
                logic [AW+31:0] e;
                e = exp_q.pop_front();
                chk("write_addr", 32'(o_MemAddr), 32'(e[AW+31:32]));
                chk("write_data", o_MemWData, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        i_Reset_n = 1'b0; i_Start = 1'b0; i_Valid = 1'b0;
        set_fields(0, 0, 0, 0, 0, 0, 0);
        model_clear();
        #23 i_Reset_n = 1'b1;
        @(posedge i_Clk); #1;
        chk("reset_ready", 32'(o_Ready), 0);
        chk("reset_we", 32'(o_MemWE), 0);
        chk("reset_wdata", o_MemWData, 0);
        check_status("reset");

        // addi x1,x0,5
        start_session();
        chk("start_ready", 32'(o_Ready), 1);
        beat(4, 1, 0, 0, 0, 0, 5, 1, 32'h00500093);

        // lw / sw / add, then beq fills memory, jal lands at 0 after restart
        start_session();
        beat(0, 2, 1, 0, 0, 0, 8, 1, 32'h0080A103);
        beat(1, 0, 1, 2, 0, 0, 12, 1, 32'h0020A623);
        beat(2, 3, 1, 2, 0, 0, 0, 1, 32'h002081B3);
        beat(3, 0, 1, 2, 0, 0, -4, 1, 32'hFE208EE3);
        chk("full_ready", 32'(o_Ready), 0);
        start_session();
        beat(5, 1, 0, 0, 0, 0, 8, 1, 32'h008000EF);

        // Illegal beats
        beat(6, 1, 1, 1, 0, 0, 0, 0, 0);
        beat(4, 1, 0, 0, 0, 0, 2048, 0, 0);
        beat(3, 0, 1, 2, 0, 0, 3, 0, 0);
        beat(5, 1, 0, 0, 0, 0, -1048578, 0, 0);
        beat(7, 1, 0, 0, 0, 0, 5000, 0, 0);

        // Fill, then a valid beat while full must be ignored
        start_session();
        for (int i = 0; i < CAP; i++) beat(4, i + 1, 0, 0, 0, 0, i, 0, 0);
        set_fields(4, 9, 9, 0, 0, 0, 1);
        i_Valid = 1'b1;
        repeat (4) @(posedge i_Clk);
        #1 i_Valid = 1'b0;
        chk("full_hold_ready", 32'(o_Ready), 0);
        check_status("full_hold");
        start_session();
        check_status("restart");
        beat(4, 4, 4, 0, 0, 0, -2048, 0, 0);

        // i_Start coincident with a handshake drops the beat
        set_fields(4, 5, 5, 0, 0, 0, 7);
        i_Valid = 1'b1;
        wait_ready(ok);
        i_Start = 1'b1;
        @(posedge i_Clk); #1;
        i_Start = 1'b0; i_Valid = 1'b0;
        model_clear();
        @(posedge i_Clk); #1;
        check_status("start_drop");
        chk("start_drop_ready", 32'(o_Ready), 1);

        // i_Start during WRITE cancels the strobe
        set_fields(4, 6, 6, 0, 0, 0, 9);
        i_Valid = 1'b1;
        wait_ready(ok);
        @(posedge i_Clk); #1;
        i_Valid = 1'b0;
        i_Start = 1'b1;
        #1 chk("start_cancel_we", 32'(o_MemWE), 0);
        @(posedge i_Clk); #1;
        i_Start = 1'b0;
        model_clear();
        check_status("start_cancel");

        // Reset asserted mid-WRITE
        set_fields(4, 7, 7, 0, 0, 0, 11);
        i_Valid = 1'b1;
        wait_ready(ok);
        @(posedge i_Clk); #1;
        i_Valid = 1'b0;
        i_Reset_n = 1'b0;
        #1;
        chk("rst_mid_we", 32'(o_MemWE), 0);
        chk("rst_mid_ready", 32'(o_Ready), 0);
        chk("rst_mid_wdata", o_MemWData, 0);
        model_clear();
        check_status("rst_mid");
        @(negedge i_Clk); #2;
        i_Reset_n = 1'b1;
        @(posedge i_Clk); #1;

        // Randomized beats against the reference model
        start_session();
        for (int i = 0; i < 80; i++) begin
            int cls, imm, sel;
            if (m_full || $urandom_range(0, 15) == 0) start_session();
            cls = $urandom_range(0, 7);
            sel = $urandom_range(0, 3);
            case (sel)
                0: imm = $urandom_range(0, 4095) - 2048;
                1: imm = $urandom_range(0, 8191) - 4096;
                2: imm = $urandom_range(0, 2097151) - 1048576;
                default: imm = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) imm = imm & ~1;
            beat(cls, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 7), $urandom_range(0, 1), imm, 0, 0);
        end

        repeat (3) @(posedge i_Clk);
        #1 chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
